// File: rtl/fp_mul_post_norm_if.sv
// Operand, multiplier and result signals of the floating-point multiply control path.
// The slave side is the control block; the master side is its environment (issuer, multiplier).
interface fp_mul_post_norm_if #(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10
);
    localparam int unsigned W = 1 + EXP_W + MAN_W;
    localparam int unsigned N = MAN_W + 1;

    logic           in_valid;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic [N-1:0]   mul_x;
    logic [N-1:0]   mul_y;
    logic [2*N-1:0] mul_z;
    logic           out_valid;
    logic [W-1:0]   out_res;
    logic           out_nan;
    logic           out_ovf;
    logic           out_unf;
    logic           out_inexact;

    modport slave (
        input  in_valid, in_a, in_b, mul_z,
        output mul_x, mul_y, out_valid, out_res, out_nan, out_ovf, out_unf, out_inexact
    );

    modport master (
        output in_valid, in_a, in_b, mul_z,
        input  mul_x, mul_y, out_valid, out_res, out_nan, out_ovf, out_unf, out_inexact
    );
endinterface

// File: rtl/fp_mul_post_norm.sv
// Floating-point multiply control path: unpack, tag delay line matched to the external
// mantissa multiplier, then normalise, round-to-nearest-even, pack and flag exceptions.
module fp_mul_post_norm #(
    parameter int unsigned EXP_W   = 5,
    parameter int unsigned MAN_W   = 10,
    parameter int unsigned BIAS    = 15,
    parameter int unsigned MUL_LAT = MAN_W
) (
    input logic               clk,
    input logic               rst,
    fp_mul_post_norm_if.slave bus
);
    localparam int unsigned N  = MAN_W + 1;
    localparam int unsigned ZW = 2 * N;
    localparam int unsigned W  = 1 + EXP_W + MAN_W;
    localparam int unsigned EW = EXP_W + 2;

    localparam logic signed [EW-1:0] EXP_MAX   = EW'(2 ** EXP_W - 1);
    localparam logic signed [EW-1:0] EXP_ZERO  = '0;
    localparam logic [MAN_W-1:0]     QNAN_FRAC = {1'b1, {(MAN_W - 1){1'b0}}};

    typedef enum logic [1:0] {ClsNorm, ClsZero, ClsInf, ClsNan} cls_e;

    typedef struct packed {
        logic            valid;
        logic            sign;
        logic [EW-1:0]   exp;
        cls_e            cls;
    } tag_t;

    logic               w_sa, w_sb;
    logic [EXP_W-1:0]   w_ea, w_eb;
    logic [MAN_W-1:0]   w_fa, w_fb;
    logic               w_a_max, w_b_max, w_a_zero, w_b_zero;
    tag_t               w_issue;

    assign {w_sa, w_ea, w_fa} = bus.in_a;
    assign {w_sb, w_eb, w_fb} = bus.in_b;
    assign bus.mul_x = {w_ea != '0, w_fa};
    assign bus.mul_y = {w_eb != '0, w_fb};

    assign w_a_max  = &w_ea;
    assign w_b_max  = &w_eb;
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);

    always_comb begin
        w_issue.valid = bus.in_valid;
        w_issue.sign  = w_sa ^ w_sb;
        w_issue.exp   = EW'(w_ea) + EW'(w_eb) - EW'(BIAS);
        if ((w_a_max && (w_fa != '0)) || (w_b_max && (w_fb != '0)) ||
            (w_a_max && w_b_zero) || (w_b_max && w_a_zero)) begin
            w_issue.cls = ClsNan;
        end else if (w_a_max || w_b_max) begin
            w_issue.cls = ClsInf;
        end else if (w_a_zero || w_b_zero) begin
            w_issue.cls = ClsZero;
        end else begin
            w_issue.cls = ClsNorm;
        end
    end

    // Tag rides alongside the free-running multiplier; it meets mul_z at the last stage.
    tag_t r_dl [MUL_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(MUL_LAT); i++) r_dl[i] <= '0;
        end else begin
            r_dl[0] <= w_issue;
            for (int i = 1; i < int'(MUL_LAT); i++) r_dl[i] <= r_dl[i-1];
        end
    end

    tag_t                   w_p0;
    logic [ZW-1:0]          w_z;
    logic [MAN_W-1:0]       w_m;
    logic                   w_g, w_s;
    logic signed [EW-1:0]   w_e;

    assign w_p0 = r_dl[MUL_LAT-1];
    assign w_z  = bus.mul_z;

    always_comb begin
        if (w_z[ZW-1]) begin
            w_m = w_z[ZW-2 -: MAN_W];
            w_g = w_z[N-1];
            w_s = |w_z[N-2:0];
            w_e = $signed(w_p0.exp) + EW'(1);
        end else begin
            w_m = w_z[ZW-3 -: MAN_W];
            w_g = w_z[N-2];
            w_s = |w_z[N-3:0];
            w_e = $signed(w_p0.exp);
        end
    end

    logic                   r_p1_valid, r_p1_sign, r_p1_g, r_p1_s;
    logic signed [EW-1:0]   r_p1_exp;
    cls_e                   r_p1_cls;
    logic [MAN_W-1:0]       r_p1_m;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p1_valid <= 1'b0;
            r_p1_sign  <= 1'b0;
            r_p1_exp   <= '0;
            r_p1_cls   <= ClsNorm;
            r_p1_m     <= '0;
            r_p1_g     <= 1'b0;
            r_p1_s     <= 1'b0;
        end else begin
            r_p1_valid <= w_p0.valid;
            r_p1_sign  <= w_p0.sign;
            r_p1_exp   <= w_e;
            r_p1_cls   <= w_p0.cls;
            r_p1_m     <= w_m;
            r_p1_g     <= w_g;
            r_p1_s     <= w_s;
        end
    end

    logic                   w_rnd_up;
    logic [MAN_W:0]         w_m_sum;
    logic signed [EW-1:0]   w_e_r;
    logic [W-1:0]           w_res;
    logic                   w_nan, w_ovf, w_unf, w_inexact;

    // A carry out of the rounded fraction means it wrapped to zero: bump the exponent.
    assign w_rnd_up = r_p1_g & (r_p1_s | r_p1_m[0]);
    assign w_m_sum  = {1'b0, r_p1_m} + (MAN_W + 1)'(w_rnd_up);
    assign w_e_r    = r_p1_exp + EW'(w_m_sum[MAN_W]);

    always_comb begin
        w_res     = '0;
        w_nan     = 1'b0;
        w_ovf     = 1'b0;
        w_unf     = 1'b0;
        w_inexact = 1'b0;
        if (r_p1_valid) begin
            unique case (r_p1_cls)
                ClsNan:  begin
                    w_res = {1'b0, {EXP_W{1'b1}}, QNAN_FRAC};
                    w_nan = 1'b1;
                end
                ClsInf:  w_res = {r_p1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                ClsZero: w_res = {r_p1_sign, {(EXP_W + MAN_W){1'b0}}};
                default: begin
                    if (w_e_r >= EXP_MAX) begin
                        w_res     = {r_p1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        w_ovf     = 1'b1;
                        w_inexact = 1'b1;
                    end else if (w_e_r <= EXP_ZERO) begin
                        w_res     = {r_p1_sign, {(EXP_W + MAN_W){1'b0}}};
                        w_unf     = 1'b1;
                        w_inexact = 1'b1;
                    end else begin
                        w_res     = {r_p1_sign, w_e_r[EXP_W-1:0], w_m_sum[MAN_W-1:0]};
                        w_inexact = r_p1_g | r_p1_s;
                    end
                end
            endcase
        end
    end

    logic           r_out_valid, r_out_nan, r_out_ovf, r_out_unf, r_out_inexact;
    logic [W-1:0]   r_out_res;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid   <= 1'b0;
            r_out_res     <= '0;
            r_out_nan     <= 1'b0;
            r_out_ovf     <= 1'b0;
            r_out_unf     <= 1'b0;
            r_out_inexact <= 1'b0;
        end else begin
            r_out_valid   <= r_p1_valid;
            r_out_res     <= w_res;
            r_out_nan     <= w_nan;
            r_out_ovf     <= w_ovf;
            r_out_unf     <= w_unf;
            r_out_inexact <= w_inexact;
        end
    end

    assign bus.out_valid   = r_out_valid;
    assign bus.out_res     = r_out_res;
    assign bus.out_nan     = r_out_nan;
    assign bus.out_ovf     = r_out_ovf;
    assign bus.out_unf     = r_out_unf;
    assign bus.out_inexact = r_out_inexact;
endmodule

// File: tb/tb_fp_mul_post_norm.sv
// Bench for fp_mul_post_norm with a behavioural pipelined mantissa multiplier; expected
// results are queued at issue time and checked in order by an independent output monitor.
module tb_fp_mul_post_norm;
    localparam int EXP_W   = 5;
    localparam int MAN_W   = 10;
    localparam int BIAS    = 15;
    localparam int MUL_LAT = MAN_W;
    localparam int N       = MAN_W + 1;
    localparam int LAT     = MUL_LAT + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_mul_post_norm_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

    fp_mul_post_norm #(
        .EXP_W  (EXP_W),
        .MAN_W  (MAN_W),
        .BIAS   (BIAS),
        .MUL_LAT(MUL_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running multiplier: product of mul_x/mul_y appears MUL_LAT cycles later.
    logic [2*N-1:0] mul_pipe [MUL_LAT];
    always @(posedge clk) begin
        mul_pipe[0] <= (2*N)'(bus.mul_x) * (2*N)'(bus.mul_y);
        for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
    end
    assign bus.mul_z = mul_pipe[MUL_LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] res;
        logic        nan;
        logic        ovf;
        logic        unf;
        logic        inx;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 1'b0;

    function automatic exp_t mk(logic [15:0] r, logic n, logic o, logic u, logic x);
        exp_t e;
        e.res = r; e.nan = n; e.ovf = o; e.unf = u; e.inx = x; e.due = 0;
        return e;
    endfunction

    // Reference: exact integer product, then round the real value to 11 significant bits.
    function automatic exp_t model(logic [15:0] a, logic [15:0] b);
        logic        s;
        int          ea, eb, fa, fb, e, sh, q, rem, half;
        longint      p;
        bit          amax, bmax, azero, bzero;
        s  = a[15] ^ b[15];
        ea = int'(a[14:10]); eb = int'(b[14:10]);
        fa = int'(a[9:0]);   fb = int'(b[9:0]);
        amax = (ea == 31); bmax = (eb == 31);
        azero = (ea == 0); bzero = (eb == 0);
        if ((amax && fa != 0) || (bmax && fb != 0) || (amax && bzero) || (bmax && azero))
            return mk(16'h7E00, 1'b1, 1'b0, 1'b0, 1'b0);
        if (amax || bmax) return mk({s, 15'h7C00}, 1'b0, 1'b0, 1'b0, 1'b0);
        if (azero || bzero) return mk({s, 15'h0000}, 1'b0, 1'b0, 1'b0, 1'b0);
        p = longint'(1024 + fa) * longint'(1024 + fb);
        e = ea + eb - BIAS;
        if (p >= (64'd1 << 21)) begin sh = 11; e = e + 1; end
        else sh = 10;
        q    = int'(p >> sh);
        rem  = int'(p % (64'd1 << sh));
        half = 1 << (sh - 1);
        if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
        if (q == 2048) begin q = 1024; e = e + 1; end
        if (e >= 31) return mk({s, 15'h7C00}, 1'b0, 1'b1, 1'b0, 1'b1);
        if (e <= 0)  return mk({s, 15'h0000}, 1'b0, 1'b0, 1'b1, 1'b1);
        return mk({s, 5'(e), 10'(q - 1024)}, 1'b0, 1'b0, 1'b0, rem != 0);
    endfunction

    task automatic send(input logic [15:0] a, input logic [15:0] b, input exp_t e,
                        input bit keep);
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        e.due        = cyc + LAT;
        if (keep) sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            bus.in_a     = 16'($urandom);
            bus.in_b     = 16'($urandom);
        end
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 200;
        while (sb.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_%s: %0d results outstanding, required 0", tag, sb.size());
            sb.delete();
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            n_tests++;
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output cyc=%0d got res=%h, required no output",
                             cyc, bus.out_res);
                end else begin
                    e = sb.pop_front();
                    if (bus.out_res !== e.res || bus.out_nan !== e.nan || bus.out_ovf !== e.ovf ||
                        bus.out_unf !== e.unf || bus.out_inexact !== e.inx || cyc != e.due) begin
                        n_fail++;
                        $display("FAIL result cyc=%0d got res=%h n=%b o=%b u=%b x=%b, required res=%h n=%b o=%b u=%b x=%b at cyc=%0d",
                                 cyc, bus.out_res, bus.out_nan, bus.out_ovf, bus.out_unf,
                                 bus.out_inexact, e.res, e.nan, e.ovf, e.unf, e.inx, e.due);
                    end
                end
            end else begin
                if (bus.out_res !== '0 || bus.out_nan || bus.out_ovf || bus.out_unf ||
                    bus.out_inexact) begin
                    n_fail++;
                    $display("FAIL idle_outputs cyc=%0d got res=%h flags=%b%b%b%b, required 0",
                             cyc, bus.out_res, bus.out_nan, bus.out_ovf, bus.out_unf,
                             bus.out_inexact);
                end
                if (sb.size() != 0 && sb[0].due <= cyc) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL missing_output cyc=%0d got out_valid=0, required res=%h due cyc=%0d",
                             cyc, sb[0].res, sb[0].due);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a, b;
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        rst          = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.out_res !== '0 || bus.out_nan || bus.out_ovf ||
            bus.out_unf || bus.out_inexact) begin
            n_fail++;
            $display("FAIL reset_state got valid=%b res=%h, required valid=0 res=0000 flags=0",
                     bus.out_valid, bus.out_res);
        end
        @(posedge clk); #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        send(16'h3C00, 16'h3C00, mk(16'h3C00, 0, 0, 0, 0), 1'b1);
        send(16'h3E00, 16'h3E00, mk(16'h4080, 0, 0, 0, 0), 1'b1);
        send(16'h3C01, 16'h3E00, mk(16'h3E02, 0, 0, 0, 1), 1'b1);
        send(16'h7BFF, 16'h7BFF, mk(16'h7C00, 0, 1, 0, 1), 1'b1);
        send(16'h0400, 16'h0400, mk(16'h0000, 0, 0, 1, 1), 1'b1);
        idle(1);
        send(16'h8400, 16'h0400, mk(16'h8000, 0, 0, 1, 1), 1'b1);
        send(16'h7C00, 16'h0000, mk(16'h7E00, 1, 0, 0, 0), 1'b1);
        send(16'h7C00, 16'hC000, mk(16'hFC00, 0, 0, 0, 0), 1'b1);
        idle(2);

        // Random normal operands, mostly in range, with occasional bubbles.
        for (int i = 0; i < 40; i++) begin
            if (i % 5 == 4) begin
                a = {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
                b = {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
            end else begin
                a = {1'($urandom), 5'($urandom_range(8, 22)), 10'($urandom)};
                b = {1'($urandom), 5'($urandom_range(8, 22)), 10'($urandom)};
            end
            send(a, b, model(a, b), 1'b1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        // Unrestricted bit patterns reach the special classes and subnormal flushing.
        for (int i = 0; i < 30; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (i % 6 == 0) a[14:10] = 5'h1F;
            if (i % 7 == 0) b[14:10] = 5'h00;
            send(a, b, model(a, b), 1'b1);
        end
        idle(1);
        drain("stream");

        // Ops caught in flight by a reset must never emerge.
        for (int i = 0; i < 4; i++) send(16'h4000 + 16'(i), 16'h3C00, mk(0, 0, 0, 0, 0), 1'b0);
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_a     = 16'h4400;
        bus.in_b     = 16'h4400;
        rst          = 1'b1;
        @(posedge clk); #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        send(16'h4000, 16'h4200, mk(16'h4600, 0, 0, 0, 0), 1'b1);
        idle(LAT + 4);
        drain("after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
